reorder_emitter: RTL and testbench
==================================

Name: reorder_emitter

Overview:
- Reader/consumer side of the packet status table.
- Allocates reorder tags to packets entering the circular buffer.
- Drives the head tag (cb_reorder_tag) into the status table and reads back the 2-bit status for that tag.
- Releases packets strictly in tag order: accepted packets are emitted downstream, rejected packets are dropped, pending packets stall the head.

Parameters:
- TAG_WIDTH, 6, width of reorder tags.
- CIRCULAR_BUFFER_SIZE, 50, number of tags in use; tags wrap from CIRCULAR_BUFFER_SIZE-1 to 0; must be <= 2**TAG_WIDTH.
- TIMEOUT_CYCLES, 1024, pending-timeout limit; used only with the optional feature.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- alloc_req  in  1  new packet requests a tag
- alloc_grant  out  1  combinational: alloc_req && !full
- alloc_tag  out  TAG_WIDTH  tail pointer; valid when alloc_grant is high
- cb_reorder_tag  out  TAG_WIDTH  head tag to status table (registered)
- cb_rd_packet_status  in  2  status of head tag: 00 pending, 01 rejected, 11 accepted
- emit_valid  out  1  head packet accepted, awaiting downstream
- emit_ready  in  1  downstream accepts
- emit_tag  out  TAG_WIDTH  tag being emitted (equals cb_reorder_tag)
- drop_valid  out  1  one-cycle pulse: head packet rejected
- drop_tag  out  TAG_WIDTH  tag being dropped
- occupancy  out  TAG_WIDTH+1  tags allocated and not yet freed
- full  out  1  occupancy == CIRCULAR_BUFFER_SIZE
- empty  out  1  occupancy == 0
- status_error  out  1  sticky: status 10 was seen at the head
- timeout_drop  out  1  pulse: drop forced by timeout (optional feature)

Behaviour:
- Reset (synchronous, active-high): head=0, tail=0, occupancy=0, state=EMPTY.
- All outputs 0 during and after reset, except empty=1.
- rst asserted mid-operation discards all in-flight state at that edge; any pending emit_valid drops without a handshake.
- Allocation: on alloc_grant, tail advances with wrap (CIRCULAR_BUFFER_SIZE-1 -> 0) and occupancy increments.
- States:
  - EMPTY: idle. Go to CHECK when occupancy > 0.
  - CHECK: sample cb_rd_packet_status each cycle.
    - 00: stay.
    - 11: go to EMIT.
    - 01: go to DROP.
    - 10: stay (treated as pending) and set status_error.
  - EMIT: emit_valid=1, held stable with emit_tag until emit_valid && emit_ready. On that edge head advances with wrap; go to SETTLE.
  - DROP: drop_valid=1 for exactly one cycle. Head advances with wrap at the end of that cycle; go to SETTLE.
  - SETTLE: one cycle. The status table clears the previous head entry during this cycle. occupancy decrements this cycle. Then go to CHECK if occupancy after the decrement is > 0, else go to EMPTY.
- Latency:
  - Status 11 first visible in cycle N -> emit_valid in N+1.
  - Status 01 in cycle N -> drop_valid in N+1.
  - Minimum 3 cycles per packet (CHECK, EMIT/DROP, SETTLE).
- Freed-tag rule: a tag becomes allocatable only after its SETTLE cycle. This prevents reallocation before the status table has cleared the entry.
- Simultaneous grant and SETTLE decrement: occupancy unchanged.
- When full: alloc_grant=0 and tail holds. A grant in the same cycle as the SETTLE decrement is still refused, because full is computed from registered occupancy.
- Head passing tail: impossible. CHECK is entered only with occupancy > 0.
- Stale status: BPF writes for tags not currently allocated are undefined. They are not checked.

Optional Feature:
- Macro ORDER_TIMEOUT_EN.
- Defined:
  - A pending counter runs in CHECK while status is 00 or 10, and clears on any exit from CHECK.
  - When the counter reaches TIMEOUT_CYCLES-1, the next state is DROP. timeout_drop pulses together with drop_valid.
- Undefined: no counter. The head waits indefinitely on pending. timeout_drop is tied to 0.

Test Plan:
- In-order accept: allocate tags 0,1,2; status 11 for 0,1,2; emit_ready=1 -> emit_tag 0,1,2 in order, 3 cycles apart; occupancy ends at 0; empty=1.
- Out-of-order completion: status 11 for tag 1, then for tag 0 five cycles later -> no emit until tag 0 completes; then tag 0 emits, then tag 1.
- Reject: tag 0 status 01 -> drop_valid for exactly one cycle with drop_tag=0; tag 1 becomes the head next.
- Backpressure: tag 0 accepted, emit_ready low for 4 cycles -> emit_valid and emit_tag=0 held stable; head advances only on the handshake.
- Full and wrap: allocate 50 tags -> full=1 and a 51st alloc_req is refused; emit tag 0 -> the grant is refused during SETTLE and allowed the next cycle with alloc_tag=0; allocate through tag 49 and wrap back to 0.
- Reset mid-EMIT and illegal status: rst high while emit_valid=1 -> the next cycle shows all outputs 0 and empty=1. Separately, status 10 at the head -> status_error=1 (sticky) and the head holds. With ORDER_TIMEOUT_EN and TIMEOUT_CYCLES=8, a pending head is dropped with timeout_drop=1.

Source files
------------

// File: rtl/reorder_emitter.sv
// -----------------------------------------------------------------------------
// reorder_emitter
//
// Consumer side of the packet status table. Packets entering the circular
// buffer are given reorder tags in allocation order (tail pointer). The head
// tag is driven to the status table. The 2-bit status read back decides what
// happens to the head packet:
//   00 pending  -> head stalls
//   11 accepted -> packet is offered downstream (emit_valid/emit_ready)
//   01 rejected -> packet is dropped (one-cycle drop_valid pulse)
//   10 illegal  -> treated as pending and recorded in the sticky status_error
// Packets therefore leave strictly in tag order.
//
// Handshake: emit_valid and emit_tag stay stable until a cycle where both
// emit_valid and emit_ready are high. The transfer happens on that clock edge.
// drop_valid is a pulse that needs no acknowledge.
//
// Optional feature (macro ORDER_TIMEOUT_EN): a head that stays pending for
// TIMEOUT_CYCLES cycles in CHECK is force-dropped, and timeout_drop pulses
// together with drop_valid. Without the macro, timeout_drop is tied to 0.
//
// Ports
//   clk                  clock
//   rst                  synchronous active-high reset
//   alloc_req            new packet requests a tag
//   alloc_grant          alloc_req && !full (combinational)
//   alloc_tag            tail tag, valid with alloc_grant
//   cb_reorder_tag       registered head tag to the status table
//   cb_rd_packet_status  status of the head tag
//   emit_valid           head accepted, waiting for downstream
//   emit_ready           downstream accepts
//   emit_tag             tag being emitted (== cb_reorder_tag)
//   drop_valid           one-cycle pulse: head rejected
//   drop_tag             tag being dropped (== cb_reorder_tag)
//   occupancy            tags allocated and not yet freed
//   full                 occupancy == CIRCULAR_BUFFER_SIZE
//   empty                occupancy == 0
//   status_error         sticky: status 10 seen at the head
//   timeout_drop         pulse: drop forced by the pending timeout
// -----------------------------------------------------------------------------
module reorder_emitter #(
    parameter int TAG_WIDTH            = 6,
    parameter int CIRCULAR_BUFFER_SIZE = 50,
    parameter int TIMEOUT_CYCLES       = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alloc_req,
    output logic                 alloc_grant,
    output logic [TAG_WIDTH-1:0] alloc_tag,
    output logic [TAG_WIDTH-1:0] cb_reorder_tag,
    input  logic [1:0]           cb_rd_packet_status,
    output logic                 emit_valid,
    input  logic                 emit_ready,
    output logic [TAG_WIDTH-1:0] emit_tag,
    output logic                 drop_valid,
    output logic [TAG_WIDTH-1:0] drop_tag,
    output logic [TAG_WIDTH:0]   occupancy,
    output logic                 full,
    output logic                 empty,
    output logic                 status_error,
    output logic                 timeout_drop
);

    // Elaboration-time sanity check on the parameter set.
    if (CIRCULAR_BUFFER_SIZE > (2 ** TAG_WIDTH) || CIRCULAR_BUFFER_SIZE < 1 ||
        TIMEOUT_CYCLES < 2) begin : g_bad_params
        $error("reorder_emitter: illegal parameter combination");
    end

    localparam logic [TAG_WIDTH-1:0] LP_LAST_TAG = TAG_WIDTH'(CIRCULAR_BUFFER_SIZE - 1);
    localparam logic [TAG_WIDTH:0]   LP_FULL_OCC = (TAG_WIDTH + 1)'(CIRCULAR_BUFFER_SIZE);

    localparam logic [1:0] LP_ST_PENDING  = 2'b00;
    localparam logic [1:0] LP_ST_REJECTED = 2'b01;
    localparam logic [1:0] LP_ST_ILLEGAL  = 2'b10;
    localparam logic [1:0] LP_ST_ACCEPTED = 2'b11;

    typedef enum logic [2:0] {
        ST_EMPTY  = 3'd0,
        ST_CHECK  = 3'd1,
        ST_EMIT   = 3'd2,
        ST_DROP   = 3'd3,
        ST_SETTLE = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [TAG_WIDTH-1:0]  r_head;
    logic [TAG_WIDTH-1:0]  r_tail;
    logic [TAG_WIDTH:0]    r_occ;
    logic                  r_status_error;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_grant;
    logic                  w_free;
    logic                  w_head_adv;
    logic                  w_pending;
    logic                  w_timeout_hit;
    logic [TAG_WIDTH:0]    w_occ_next;
    logic                  w_emit_valid;
    logic                  w_drop_valid;

    function automatic logic [TAG_WIDTH-1:0] next_tag(input logic [TAG_WIDTH-1:0] t);
        return (t == LP_LAST_TAG) ? '0 : t + 1'b1;
    endfunction

    // full/empty come from the registered occupancy, so a tag freed in SETTLE
    // only becomes allocatable in the following cycle. This keeps a tag from
    // being reissued while the status table is still clearing its entry.
    assign w_full  = (r_occ == LP_FULL_OCC);
    assign w_empty = (r_occ == '0);
    // No grant is issued in a reset cycle, so alloc_grant reads 0 during reset.
    assign w_grant = alloc_req && !w_full && !rst;

    assign w_free     = (r_state == ST_SETTLE);
    assign w_head_adv = ((r_state == ST_EMIT) && emit_ready) || (r_state == ST_DROP);
    // Status 10 is handled exactly like 00 for stalling and timeout purposes.
    assign w_pending  = (cb_rd_packet_status == LP_ST_PENDING) ||
                        (cb_rd_packet_status == LP_ST_ILLEGAL);

    // A grant and a free in the same cycle cancel out.
    always_comb begin
        w_occ_next = r_occ;
        case ({w_grant, w_free})
            2'b10:   w_occ_next = r_occ + 1'b1;
            2'b01:   w_occ_next = r_occ - 1'b1;
            default: w_occ_next = r_occ;
        endcase
    end

`ifdef ORDER_TIMEOUT_EN
    localparam int LP_TO_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [LP_TO_W-1:0] LP_TO_LAST = LP_TO_W'(TIMEOUT_CYCLES - 1);

    logic [LP_TO_W-1:0] r_pend_cnt;
    logic               r_timeout;

    assign w_timeout_hit = (r_state == ST_CHECK) && w_pending && (r_pend_cnt == LP_TO_LAST);

    // The counter only runs while the head sits pending in CHECK; any exit
    // from CHECK (including the timeout itself) restarts it from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            if ((r_state == ST_CHECK) && w_pending && !w_timeout_hit) begin
                r_pend_cnt <= r_pend_cnt + 1'b1;
            end else begin
                r_pend_cnt <= '0;
            end
            // Registered alongside the move to DROP so it lines up with drop_valid.
            r_timeout <= w_timeout_hit;
        end
    end

    assign timeout_drop = r_timeout;
`else
    assign w_timeout_hit = 1'b0;
    assign timeout_drop  = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and FSM outputs.
    always_comb begin
        w_state_next = r_state;
        w_emit_valid = 1'b0;
        w_drop_valid = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (!w_empty) begin
                    w_state_next = ST_CHECK;
                end
            end
            ST_CHECK: begin
                case (cb_rd_packet_status)
                    LP_ST_ACCEPTED: w_state_next = ST_EMIT;
                    LP_ST_REJECTED: w_state_next = ST_DROP;
                    default: begin
                        if (w_timeout_hit) begin
                            w_state_next = ST_DROP;
                        end
                    end
                endcase
            end
            ST_EMIT: begin
                w_emit_valid = 1'b1;
                if (emit_ready) begin
                    w_state_next = ST_SETTLE;
                end
            end
            ST_DROP: begin
                w_drop_valid = 1'b1;
                w_state_next = ST_SETTLE;
            end
            ST_SETTLE: begin
                // Decide on the post-decrement occupancy so the FSM parks in
                // EMPTY once the last tag is freed.
                w_state_next = (w_occ_next != '0) ? ST_CHECK : ST_EMPTY;
            end
            default: begin
                w_state_next = ST_EMPTY;
            end
        endcase
    end

    // Pointers, occupancy and the sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head         <= '0;
            r_tail         <= '0;
            r_occ          <= '0;
            r_status_error <= 1'b0;
        end else begin
            if (w_grant) begin
                r_tail <= next_tag(r_tail);
            end
            if (w_head_adv) begin
                r_head <= next_tag(r_head);
            end
            r_occ <= w_occ_next;
            if ((r_state == ST_CHECK) && (cb_rd_packet_status == LP_ST_ILLEGAL)) begin
                r_status_error <= 1'b1;
            end
        end
    end

    assign alloc_grant    = w_grant;
    assign alloc_tag      = r_tail;
    assign cb_reorder_tag = r_head;
    assign emit_valid     = w_emit_valid;
    assign emit_tag       = r_head;
    assign drop_valid     = w_drop_valid;
    assign drop_tag       = r_head;
    assign occupancy      = r_occ;
    assign full           = w_full;
    assign empty          = w_empty;
    assign status_error   = r_status_error;

endmodule

// File: tb/tb_reorder_emitter.sv
module tb_reorder_emitter;

  localparam int TW = 6;
  localparam int CBS = 50;

  logic          clk = 1'b0;
  logic          rst;
  logic          alloc_req;
  logic          alloc_grant;
  logic [TW-1:0] alloc_tag;
  logic [TW-1:0] cb_reorder_tag;
  logic [1:0]    cb_rd_packet_status;
  logic          emit_valid;
  logic          emit_ready;
  logic [TW-1:0] emit_tag;
  logic          drop_valid;
  logic [TW-1:0] drop_tag;
  logic [TW:0]   occupancy;
  logic          full;
  logic          empty;
  logic          status_error;
  logic          timeout_drop;

  // status table model, indexed by the head tag
  logic [1:0] stat_mem [0:63];
  assign cb_rd_packet_status = stat_mem[cb_reorder_tag];

  // scoreboard
  logic [TW-1:0] exp_q[$];
  logic [TW-1:0] drop_q[$];
  logic          exp_to;
  int            total;
  int            bad;
  int            cyc;
  int            last_emit_cyc;
  int            emit_cyc_q[$];
  int            b_tail;

  reorder_emitter #(
    .TAG_WIDTH(TW),
    .CIRCULAR_BUFFER_SIZE(CBS),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .alloc_req(alloc_req),
    .alloc_grant(alloc_grant),
    .alloc_tag(alloc_tag),
    .cb_reorder_tag(cb_reorder_tag),
    .cb_rd_packet_status(cb_rd_packet_status),
    .emit_valid(emit_valid),
    .emit_ready(emit_ready),
    .emit_tag(emit_tag),
    .drop_valid(drop_valid),
    .drop_tag(drop_tag),
    .occupancy(occupancy),
    .full(full),
    .empty(empty),
    .status_error(status_error),
    .timeout_drop(timeout_drop)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes at negedge, then advance past the posedge.
  task automatic tick();
    @(negedge clk);
    if (!rst) begin
      if (emit_valid && emit_ready) begin
        chk("emit_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) chk("emit_tag", 32'(emit_tag), 32'(exp_q.pop_front()));
        emit_cyc_q.push_back(cyc);
        last_emit_cyc = cyc;
      end
      if (drop_valid) begin
        chk("drop_expected", 32'(drop_q.size() > 0), 32'd1);
        if (drop_q.size() > 0) chk("drop_tag", 32'(drop_tag), 32'(drop_q.pop_front()));
        chk("timeout_drop", 32'(timeout_drop), 32'(exp_to));
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_alloc(input int n);
    for (int i = 0; i < n; i++) begin
      stat_mem[b_tail] = 2'b00;
      alloc_req = 1'b1;
      #1;
      chk("alloc_grant", 32'(alloc_grant), 32'd1);
      chk("alloc_tag", 32'(alloc_tag), 32'(b_tail));
      tick();
      b_tail = (b_tail == CBS - 1) ? 0 : b_tail + 1;
    end
    alloc_req = 1'b0;
  endtask

  task automatic wait_drain(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (exp_q.size() == 0 && drop_q.size() == 0) break;
      tick();
    end
    chk("drain_left", 32'(exp_q.size() + drop_q.size()), 32'd0);
  endtask

  task automatic wait_emit_valid(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (emit_valid) break;
      tick();
    end
    chk("emit_valid_wait", 32'(emit_valid), 32'd1);
  endtask

  task automatic chk_idle(input string pfx);
    chk({pfx, "_alloc_grant"}, 32'(alloc_grant), 32'd0);
    chk({pfx, "_alloc_tag"}, 32'(alloc_tag), 32'd0);
    chk({pfx, "_head"}, 32'(cb_reorder_tag), 32'd0);
    chk({pfx, "_emit_valid"}, 32'(emit_valid), 32'd0);
    chk({pfx, "_emit_tag"}, 32'(emit_tag), 32'd0);
    chk({pfx, "_drop_valid"}, 32'(drop_valid), 32'd0);
    chk({pfx, "_occupancy"}, 32'(occupancy), 32'd0);
    chk({pfx, "_full"}, 32'(full), 32'd0);
    chk({pfx, "_empty"}, 32'(empty), 32'd1);
    chk({pfx, "_status_error"}, 32'(status_error), 32'd0);
    chk({pfx, "_timeout_drop"}, 32'(timeout_drop), 32'd0);
  endtask

  initial begin
    total = 0;
    bad = 0;
    cyc = 0;
    last_emit_cyc = 0;
    b_tail = 0;
    exp_to = 1'b0;
    rst = 1'b1;
    alloc_req = 1'b0;
    emit_ready = 1'b1;
    for (int i = 0; i < 64; i++) stat_mem[i] = 2'b00;

    // reset state
    @(posedge clk);
    #1;
    tick();
    chk_idle("reset");
    rst = 1'b0;
    tick();

    // in-order accept: tags 0,1,2, one emit every 3 cycles
    do_alloc(3);
    emit_cyc_q.delete();
    for (int t = 0; t < 3; t++) begin
      stat_mem[t] = 2'b11;
      exp_q.push_back(TW'(t));
    end
    wait_drain(40);
    chk("inorder_count", 32'(emit_cyc_q.size()), 32'd3);
    if (emit_cyc_q.size() == 3) begin
      chk("inorder_gap01", 32'(emit_cyc_q[1] - emit_cyc_q[0]), 32'd3);
      chk("inorder_gap12", 32'(emit_cyc_q[2] - emit_cyc_q[1]), 32'd3);
    end
    wait_cycles(3);
    chk("inorder_occ", 32'(occupancy), 32'd0);
    chk("inorder_empty", 32'(empty), 32'd1);

    // out-of-order completion: tag 4 done first, tag 3 five cycles later
    do_alloc(2);
    emit_cyc_q.delete();
    stat_mem[4] = 2'b11;
    wait_cycles(5);
    chk("ooo_no_emit", 32'(emit_cyc_q.size()), 32'd0);
    chk("ooo_emit_valid", 32'(emit_valid), 32'd0);
    chk("ooo_head", 32'(cb_reorder_tag), 32'd3);
    stat_mem[3] = 2'b11;
    exp_q.push_back(TW'(3));
    exp_q.push_back(TW'(4));
    wait_drain(30);
    wait_cycles(3);

    // reject: tag 5 dropped, tag 6 emitted after it
    do_alloc(2);
    drop_q.push_back(TW'(5));
    exp_q.push_back(TW'(6));
    stat_mem[5] = 2'b01;
    stat_mem[6] = 2'b11;
    wait_drain(30);
    wait_cycles(3);
    chk("reject_occ", 32'(occupancy), 32'd0);

    // backpressure: tag 7 held for 4 cycles with emit_ready low
    emit_ready = 1'b0;
    do_alloc(1);
    stat_mem[7] = 2'b11;
    exp_q.push_back(TW'(7));
    wait_emit_valid(20);
    for (int k = 0; k < 4; k++) begin
      chk("bp_emit_valid", 32'(emit_valid), 32'd1);
      chk("bp_emit_tag", 32'(emit_tag), 32'd7);
      chk("bp_head", 32'(cb_reorder_tag), 32'd7);
      tick();
    end
    emit_ready = 1'b1;
    wait_drain(10);
    wait_cycles(3);
    chk("bp_head_adv", 32'(cb_reorder_tag), 32'd8);

    // full and wrap: 50 tags from 8 through 49 and back to 7
    do_alloc(CBS);
    chk("full_flag", 32'(full), 32'd1);
    chk("full_occ", 32'(occupancy), 32'd50);
    alloc_req = 1'b1;
    #1;
    chk("full_refused", 32'(alloc_grant), 32'd0);
    chk("full_tail_hold", 32'(alloc_tag), 32'd8);
    stat_mem[8] = 2'b11;
    exp_q.push_back(TW'(8));
    for (int i = 0; i < 20; i++) begin
      if (alloc_grant) break;
      tick();
    end
    chk("settle_grant", 32'(alloc_grant), 32'd1);
    chk("settle_grant_cycle", 32'(cyc - last_emit_cyc), 32'd2);
    chk("settle_alloc_tag", 32'(alloc_tag), 32'd8);
    tick();
    b_tail = 9;
    alloc_req = 1'b0;
    chk("refill_full", 32'(full), 32'd1);
    chk("refill_occ", 32'(occupancy), 32'd50);
    chk("refill_head", 32'(cb_reorder_tag), 32'd9);

    // reset in the middle of EMIT
    emit_ready = 1'b0;
    stat_mem[9] = 2'b11;
    wait_emit_valid(20);
    chk("pre_rst_emit_tag", 32'(emit_tag), 32'd9);
    rst = 1'b1;
    tick();
    chk_idle("mid_rst");
    rst = 1'b0;
    b_tail = 0;
    for (int i = 0; i < 64; i++) stat_mem[i] = 2'b00;
    tick();

    // illegal status 10: sticky error, head holds
    emit_ready = 1'b1;
    do_alloc(1);
    stat_mem[0] = 2'b10;
    wait_cycles(4);
    chk("illegal_err", 32'(status_error), 32'd1);
    chk("illegal_head", 32'(cb_reorder_tag), 32'd0);
    chk("illegal_emit", 32'(emit_valid), 32'd0);
    chk("illegal_drop", 32'(drop_valid), 32'd0);
    stat_mem[0] = 2'b11;
    exp_q.push_back(TW'(0));
    wait_drain(20);
    wait_cycles(3);
    chk("illegal_sticky", 32'(status_error), 32'd1);
    chk("illegal_empty", 32'(empty), 32'd1);

`ifdef ORDER_TIMEOUT_EN
    // pending head force-dropped after 8 cycles
    do_alloc(1);
    drop_q.push_back(TW'(1));
    exp_to = 1'b1;
    wait_drain(40);
    exp_to = 1'b0;
    wait_cycles(3);
    chk("timeout_empty", 32'(empty), 32'd1);
`endif

    chk("final_exp_q", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
